pwf_multi: RTL
==============

// Module: pwf_multi
// PURPOSE
//  N-channel pulse-width filter (debouncer) for slow digital inputs on the clk4m domain.
//  Per channel, output c[i] sets only after a[i] is sampled high HI_CNT consecutive cycles.
//  c[i] clears after a[i] is sampled low LO_CNT consecutive cycles.
//  Emits one-cycle rise/fall event pulses; sits between board inputs and control logic.
// PARAMETERS
//  N       4   number of independent channels (>=1)
//  HI_CNT  13  consecutive high samples required to set c[i] (>=1)
//  LO_CNT  1   consecutive low samples required to clear c[i] (>=1; 1 = release on first low)
//  CW      $clog2(max(HI_CNT,LO_CNT)+1)  counter width (derived localparam, not overridable)
// PORTS
//  clk4m  in   1  system clock, rising-edge active
//  rst    in   1  asynchronous reset, active-high
//  en     in   1  filter enable; low = freeze all channel state
//  a      in   N  raw inputs, one per channel
//  c      out  N  filtered levels, registered
//  rise   out  N  1-cycle pulse when c[i] goes 0->1, registered
//  fall   out  N  1-cycle pulse when c[i] goes 1->0, registered
// BEHAVIOUR
//  - Clock and reset: one clock (clk4m); reset is asynchronous and active-high (rst).
//  - Reset: c, rise, fall, all counters (and sync flops if compiled in) = 0 immediately on rst.
//    Reset mid-count or while c=1 clears the channel. After release, a full HI_CNT run is needed.
//  - Per channel, sampled input s = a[i] (or synchronised a[i], see CONFIGURATION).
//  - State c=0:
//    - s=1: cnt++. When s=1 on the HI_CNT-th consecutive edge: c<=1, rise<=1, cnt<=0, same edge.
//    - s=0: cnt<=0.
//  - State c=1:
//    - s=0: cnt++. When s=0 on the LO_CNT-th consecutive edge: c<=0, fall<=1, cnt<=0.
//    - s=1: cnt<=0.
//  - Latency: rising a seen at edge k (run starting at edge k) -> c high after edge k+HI_CNT-1.
//    Falling is analogous with LO_CNT.
//  - Counter never exceeds max(HI_CNT,LO_CNT)-1; no wrap-around possible.
//  - HI_CNT=1: c follows s with 1-cycle register delay on rise.
//    HI_CNT=LO_CNT=1 gives a plain registered copy.
//  - rise/fall high for exactly one cycle per transition; default 0 on every other edge.
//    rise and fall are never high together on the same channel.
//  - en=0: cnt and c hold, rise=fall=0. Sampling resumes on the first edge with en=1.
//    An interrupted high run continues from its held count; it does not restart.
//  - Channels are fully independent; simultaneous events on several channels are all reported.
//  - No combinational path from a/en to any output.
// CONFIGURATION
//  PWF_SYNC_EN defined:
//    - two-flop synchroniser per channel in front of the filter, reset to 0
//    - a may be asynchronous; all latencies +2 cycles
//  PWF_SYNC_EN undefined:
//    - a sampled directly; a must be synchronous to clk4m
//    - latencies as stated above
// TESTING  (N=4, HI_CNT=13, LO_CNT=1 unless noted; cycle counts without PWF_SYNC_EN)
//  1. a[0]=1 held 20 cycles -> c[0]=1 after 13th edge; rise[0]=1 for exactly that cycle.
//     Then a[0]=0 -> c[0]=0 next edge, fall[0] 1 cycle.
//  2. a[1] high 12 cycles, low 1, high 12 -> c[1] stays 0, rise[1] never asserts.
//  3. LO_CNT=3: c[2]=1, a[2] low 2 cycles then high -> c[2] stays 1.
//     Then low 3 cycles -> c[2]=0 after 3rd edge, fall[2] pulse.
//  4. a[0] high 8 cycles, en=0 for 5 cycles, en=1 with a[0] high -> c[0] sets after 5 more edges.
//     rise/fall stay 0 while en=0.
//  5. a[3:0]=4'b1111 together for 13 cycles -> c=4'b1111 and rise=4'b1111 on the same edge.
//  6. rst pulsed mid-count (cnt=7) and again with c=1 -> outputs 0 without a clock edge.
//     After release, 13 fresh high cycles are needed.
//     With PWF_SYNC_EN, repeat test 1 -> c[0] sets after 15th edge.

Source files
------------

// File: rtl/pwf_multi.sv
// N-channel pulse-width filter: each c[i] follows a[i] only after a run of HI_CNT highs / LO_CNT lows.
// Define PWF_SYNC_EN to add a two-flop synchroniser per channel ahead of the filter.
module pwf_multi #(
  parameter int N      = 4,
  parameter int HI_CNT = 13,
  parameter int LO_CNT = 1
) (
  input  logic         clk4m,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] a,
  output logic [N-1:0] c,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall
);

  localparam int MAX_CNT = (HI_CNT > LO_CNT) ? HI_CNT : LO_CNT;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam logic [CW-1:0] HI_LAST = CW'(HI_CNT - 1);
  localparam logic [CW-1:0] LO_LAST = CW'(LO_CNT - 1);

  logic [N-1:0] s;

`ifdef PWF_SYNC_EN
  logic [N-1:0] sync1_q;
  logic [N-1:0] sync2_q;

  always_ff @(posedge clk4m or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= a;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;
`else
  assign s = a;
`endif

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [CW-1:0] cnt_q, cnt_d;
    logic          c_q, c_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    // The counter only measures a run of samples that disagree with the current
    // level; any agreeing sample restarts it, so one counter serves both directions.
    always_comb begin
      cnt_d  = cnt_q;
      c_d    = c_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (en) begin
        if (s[i] != c_q) begin
          if (cnt_q == (c_q ? LO_LAST : HI_LAST)) begin
            cnt_d  = '0;
            c_d    = s[i];
            rise_d = s[i];
            fall_d = ~s[i];
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
    end

    always_ff @(posedge clk4m or posedge rst) begin
      if (rst) begin
        cnt_q  <= '0;
        c_q    <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        c_q    <= c_d;
        rise_q <= rise_d;
        fall_q <= fall_d;
      end
    end

    assign c[i]    = c_q;
    assign rise[i] = rise_q;
    assign fall[i] = fall_q;
  end

endmodule
